// File: rtl/muldiv_sequencer_if.sv
// Handshake/bus bundle between the EX stage and the multi-cycle mul/div sequencer.
// master drives the request side; slave is the sequencer.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             div_by_zero;

  modport master (
    output start, op, a, b, flush,
    input  stall, busy, done, result, div_by_zero
  );

  modport slave (
    input  start, op, a, b, flush,
    output stall, busy, done, result, div_by_zero
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply (radix-2 shift-add) / signed divide (restoring radix-2)
// sequencer that stalls the IF/ID/EX pipeline while an operation is in flight.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  muldiv_sequencer_if.slave bus
);
  localparam int         CNT_W  = ($clog2(WIDTH) > 5) ? $clog2(WIDTH) : 5;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_opa;      // mul: multiplicand; div: dividend -> quotient shift register
  logic [WIDTH-1:0] r_opb;      // mul: multiplier; div: divisor magnitude
  logic [WIDTH-1:0] r_acc;      // mul: partial product; div: partial remainder
  logic [WIDTH-1:0] r_result;
  logic             r_neg;
  logic             r_dbz_pend;
  logic             r_dbz;

  logic             w_valid_op;
  logic             w_is_div;
  logic             w_accept;
  logic             w_done;
  logic [WIDTH-1:0] w_rem_sh;
  logic             w_rem_ge;
  logic [WIDTH-1:0] w_final;

  function automatic logic [WIDTH-1:0] f_negate(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  // Magnitude of a two's-complement value; the most-negative value maps to 2^(WIDTH-1) unsigned.
  function automatic logic [WIDTH-1:0] f_mag(input logic signed [WIDTH-1:0] v);
    logic [WIDTH-1:0] u;
    u = v;
    return v[WIDTH-1] ? f_negate(u) : u;
  endfunction

  assign w_valid_op = (bus.op == OP_MUL) || (bus.op == OP_DIV);
  assign w_is_div   = (bus.op == OP_DIV);
  assign w_accept   = bus.start & w_valid_op & ~bus.flush;

  // Remainder stays below the divisor (<= 2^(WIDTH-1)), so its top bit is always free for the shift.
  assign w_rem_sh = {r_acc[WIDTH-2:0], r_opa[WIDTH-1]};
  assign w_rem_ge = (w_rem_sh >= r_opb);

  assign w_final = (r_op == OP_DIV)
                 ? (r_dbz_pend ? '1 : (r_neg ? f_negate(r_opa) : r_opa))
                 : r_acc;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_div && (bus.b == '0)) w_next = S_DONE;
          else if (w_is_div)             w_next = S_DIV;
          else                           w_next = S_MUL;
        end
      end
      S_MUL, S_DIV: begin
        if (bus.flush)        w_next = S_IDLE;
        else if (r_cnt == '0) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_done          = ~rst & ~bus.flush & (r_state == S_DONE);
    bus.stall       = ~rst & ~bus.flush &
                      (((r_state == S_IDLE) & bus.start & w_valid_op) |
                       (r_state == S_MUL) | (r_state == S_DIV));
    bus.busy        = (r_state == S_MUL) | (r_state == S_DIV);
    bus.done        = w_done;
    bus.result      = w_done ? w_final : r_result;
    bus.div_by_zero = w_done ? r_dbz_pend : r_dbz;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_op       <= '0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_acc      <= '0;
      r_neg      <= 1'b0;
      r_dbz_pend <= 1'b0;
      r_result   <= '0;
      r_dbz      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op  <= bus.op;
            r_cnt <= CNT_W'(WIDTH - 1);
            r_acc <= '0;
            if (w_is_div) begin
              r_opa      <= f_mag(bus.a);
              r_opb      <= f_mag(bus.b);
              r_neg      <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
              r_dbz_pend <= (bus.b == '0);
            end else begin
              r_opa      <= bus.a;
              r_opb      <= bus.b;
              r_neg      <= 1'b0;
              r_dbz_pend <= 1'b0;
            end
          end
        end
        S_MUL: begin
          if (r_opb[0]) r_acc <= r_acc + r_opa;
          r_opa <= {r_opa[WIDTH-2:0], 1'b0};
          r_opb <= {1'b0, r_opb[WIDTH-1:1]};
          r_cnt <= r_cnt - CNT_W'(1);
        end
        S_DIV: begin
          r_acc <= w_rem_ge ? (w_rem_sh - r_opb) : w_rem_sh;
          r_opa <= {r_opa[WIDTH-2:0], w_rem_ge};
          r_cnt <= r_cnt - CNT_W'(1);
        end
        S_DONE: begin
          // A flush in DONE cancels the result, so the visible outputs keep the previous value.
          if (!bus.flush) begin
            r_result <= w_final;
            r_dbz    <= r_dbz_pend;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  EX stage holds a multi-cycle ALU op; held high until done.
REQ-005 op  input  3  ALUOp; 3'b010 = mult, 3'b011 = div; other codes are not multi-cycle ops.
REQ-006 a  input  WIDTH  operand 1 / dividend, two's complement.
REQ-007 b  input  WIDTH  operand 2 / divisor, two's complement.
REQ-008 flush  input  1  pipeline flush; aborts the operation in flight.
REQ-009 stall  output  1  freezes IF/ID/EX pipeline registers.
REQ-010 busy  output  1  high in MUL or DIV state.
REQ-011 done  output  1  one-cycle pulse; result valid.
REQ-012 result  output  WIDTH  product or quotient.
REQ-013 div_by_zero  output  1  valid with done; divisor was zero.

Function
REQ-014 States: IDLE, MUL, DIV, DONE; 5-bit-or-wider iteration counter (clog2(WIDTH) bits).
REQ-015 IDLE and start, valid op, no flush: latch a, b, op; counter = WIDTH-1; go to MUL or DIV.
REQ-016 IDLE and start with invalid op: no state change, stall low.
REQ-017 stall = (IDLE & start & valid op & ~flush) | ((MUL | DIV) & ~flush); stall is low in DONE.
REQ-018 MUL: radix-2 shift-add, one multiplier bit per cycle; result = low WIDTH bits of a*b, identical for signed and unsigned operands.
REQ-019 DIV: restoring radix-2 on operand magnitudes, one quotient bit per cycle; quotient negated when operand signs differ; truncation toward zero.
REQ-020 Iteration state after the counter reaches 0 -> DONE; WIDTH cycles in MUL/DIV.
REQ-021 Latency: acceptance at cycle 0; done at cycle WIDTH+1; stall high cycles 0..WIDTH.
REQ-022 DONE: done=1 for exactly one cycle, result and div_by_zero held; next state IDLE unconditionally.
REQ-023 start is ignored in DONE; a new op is accepted only from IDLE.
REQ-024 Div with b==0: skip iterations, IDLE -> DONE; done at cycle 1; result = all ones; div_by_zero=1.
REQ-025 Div of most-negative by -1: result = most-negative value (wrap); div_by_zero=0.
REQ-026 div_by_zero=0 for every mult and for every div with nonzero b.
REQ-027 result and div_by_zero hold their last value from DONE until the next DONE.
REQ-028 flush in MUL/DIV/DONE: next state IDLE, no done pulse, result unchanged, stall low that cycle.
REQ-029 flush with start in IDLE: op not accepted.
REQ-030 rst and flush together: rst behaviour applies.

Reset
REQ-031 rst: state IDLE, counter 0, stall 0, busy 0, done 0, result 0, div_by_zero 0, internal operand registers 0.
REQ-032 rst mid-operation: abort at next edge, no done pulse; reset values from that edge.
REQ-033 After rst deasserts: op acceptance allowed in the first cycle.

Verification (WIDTH=32)
REQ-034 Mult 7 * -3: start, op=010 -> stall high 33 cycles; done at cycle 33; result=0xFFFFFFEB; div_by_zero=0.
REQ-035 Div -100 / 7: op=011 -> done at cycle 33; result=0xFFFFFFF2 (-14).
REQ-036 Div 0x80000000 / 0xFFFFFFFF -> result=0x80000000, div_by_zero=0; div 5 / 0 -> done at cycle 1, result=0xFFFFFFFF, div_by_zero=1.
REQ-037 Abort: mult started, flush at cycle 10 -> IDLE at cycle 11, no done, stall low from cycle 10, result keeps prior value; rst at cycle 10 -> same except result=0.
REQ-038 Back-to-back: two mults with start held through DONE -> second accepted only in the cycle after DONE; exactly two done pulses; op=000 with start -> stall never asserted.
